cache_1a_wt_dm: RTL and testbench

- Single-level data cache with write-through and direct-mapped organisation, bundled with its backing main memory.
- Serves one word access per clock cycle from a 10-bit byte address.
- Returns read data plus a hit flag.
- Used as the self-contained memory subsystem for the 1a simulation flow; benches probe memory contents hierarchically.

---
 rtl/cache_1a_wt_dm_pkg.sv | 36 +++
 rtl/cache_1a_wt_dm_main_memory.sv | 24 ++
 rtl/cache_1a_wt_dm.sv | 62 ++++++
 tb/tb_cache_1a_wt_dm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cache_1a_wt_dm_pkg.sv
// Shared address-field layout, sizing and main-memory power-up contents
// for the 1a write-through direct-mapped cache.
package cache_1a_wt_dm_pkg;
    localparam int ADDR_W          = 10;
    localparam int DATA_W          = 32;
    localparam int MEM_WORDS       = 256;
    localparam int NUM_BLOCKS      = 4;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int TAG_W           = 4;
    localparam int IDX_W           = 2;
    localparam int OFF_W           = 2;
    localparam int MADDR_W         = TAG_W + IDX_W + OFF_W;
    localparam int BLK_W           = TAG_W + IDX_W;
    localparam int OFF_LSB         = 2;

    localparam logic [DATA_W-1:0] INIT_0   = 32'h0000_3cc3;
    localparam logic [DATA_W-1:0] INIT_128 = 32'h0000_0ccc;
    localparam logic [DATA_W-1:0] INIT_192 = 32'h0000_00c3;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [OFF_W-1:0] off_t;

    typedef struct packed {
        tag_t tag;
        idx_t idx;
        off_t off;
    } addr_fields_t;

    typedef logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] block_t;

    // Word-aligned view of a byte address: {tag, index, offset}.
    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] a);
        return addr_fields_t'(a[ADDR_W-1:OFF_LSB]);
    endfunction
endpackage

// File: rtl/cache_1a_wt_dm_main_memory.sv
// Backing store: 256 x 32 words, whole-block combinational read for refills,
// single-word synchronous write. Contents survive reset.
module main_memory_1a
    import cache_1a_wt_dm_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [MADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [BLK_W-1:0]   blk_addr,
    output block_t             rd_block
);
    // Power-up image; deliberately outside the reset domain.
    logic [DATA_W-1:0] mem [MEM_WORDS] = '{0: INIT_0, 128: INIT_128, 192: INIT_192, default: '0};

    always_comb begin
        rd_block = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++)
            rd_block[w] = mem[{blk_addr, OFF_W'(w)}];
    end

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/cache_1a_wt_dm.sv
// Direct-mapped, write-through, write-no-allocate data cache with its
// main memory. One access per cycle; results registered.
module cache_1a_wt_dm
    import cache_1a_wt_dm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              isRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              isHit
);
    addr_fields_t          fa;
    logic [NUM_BLOCKS-1:0] valid;
    tag_t                  tags  [NUM_BLOCKS];
    block_t                lines [NUM_BLOCKS];
    block_t                blk;
    logic                  hit;
    logic                  unused_bits;

    assign fa          = split_addr(address);
    assign hit         = valid[fa.idx] && (tags[fa.idx] == fa.tag);
    assign unused_bits = &{1'b0, address[OFF_LSB-1:0]};

    // Every store goes to memory, hit or miss.
    main_memory_1a mem (
        .clk      (clk),
        .we       (req && !isRead),
        .waddr    (address[ADDR_W-1:OFF_LSB]),
        .wdata    (writeData),
        .blk_addr ({fa.tag, fa.idx}),
        .rd_block (blk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            readData <= '0;
            isHit    <= 1'b0;
        end else if (req) begin
            isHit <= hit;
            if (isRead) begin
                readData <= hit ? lines[fa.idx][fa.off] : blk[fa.off];
                if (!hit) valid[fa.idx] <= 1'b1;
            end else begin
                readData <= writeData;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (req && isRead && !hit) begin
            lines[fa.idx] <= blk;
            tags[fa.idx]  <= fa.tag;
        end else if (req && !isRead && hit) begin
            lines[fa.idx][fa.off] <= writeData;
        end
    end
endmodule

// File: tb/tb_cache_1a_wt_dm.sv
// Self-checking bench for cache_1a_wt_dm: vector table with scoreboard queue,
// plus hand sequences for idle hold and asynchronous reset.
module tb_cache_1a_wt_dm;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        isRead;
    logic [9:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        isHit;

    cache_1a_wt_dm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .isRead    (isRead),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .isHit     (isHit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_h;
        logic        probe;
        logic [7:0]  pidx;
        logic [31:0] pval;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        h;
        int          id;
    } exp_t;

    vec_t vecs [16];
    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one access at negedge, queue its expectation, compare after the edge.
    task automatic access(input logic rd, input logic [9:0] a, input logic [31:0] wd,
                          input logic [31:0] ed, input logic eh, input int id);
        exp_t e;
        @(negedge clk);
        req = 1'b1; isRead = rd; address = a; writeData = wd;
        sb.push_back('{d: ed, h: eh, id: id});
        @(posedge clk);
        #1;
        req = 1'b0;
        if (sb.size() == 0) begin
            chk($sformatf("vec%0d scoreboard empty", id), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d readData", e.id), readData, e.d);
            chk($sformatf("vec%0d isHit", e.id), {31'd0, isHit}, {31'd0, e.h});
        end
    endtask

    initial begin
        logic [31:0] held_d;
        logic        held_h;

        //            rd    addr    wd            exp_d         h     probe pidx  pval
        vecs[0]  = '{1'b1, 10'h000, 32'h0,        32'h00003cc3, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[1]  = '{1'b0, 10'h000, 32'h000000ff, 32'h000000ff, 1'b1, 1'b1, 8'd0,  32'h000000ff};
        vecs[2]  = '{1'b1, 10'h000, 32'h0,        32'h000000ff, 1'b1, 1'b0, 8'd0,  32'h0};
        vecs[3]  = '{1'b1, 10'h200, 32'h0,        32'h00000ccc, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[4]  = '{1'b1, 10'h000, 32'h0,        32'h000000ff, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[5]  = '{1'b1, 10'h300, 32'h0,        32'h000000c3, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[6]  = '{1'b1, 10'h200, 32'h0,        32'h00000ccc, 1'b0, 1'b1, 8'd0,  32'h000000ff};
        vecs[7]  = '{1'b0, 10'h044, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 8'd17, 32'h12345678};
        vecs[8]  = '{1'b1, 10'h044, 32'h0,        32'h12345678, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[9]  = '{1'b1, 10'h048, 32'h0,        32'h00000000, 1'b1, 1'b0, 8'd0,  32'h0};
        vecs[10] = '{1'b0, 10'h04c, 32'hdeadbeef, 32'hdeadbeef, 1'b1, 1'b1, 8'd19, 32'hdeadbeef};
        vecs[11] = '{1'b1, 10'h04f, 32'h0,        32'hdeadbeef, 1'b1, 1'b0, 8'd0,  32'h0};
        vecs[12] = '{1'b1, 10'h3f0, 32'h0,        32'h00000000, 1'b0, 1'b0, 8'd0,  32'h0};
        vecs[13] = '{1'b0, 10'h3f4, 32'hcafe0001, 32'hcafe0001, 1'b1, 1'b1, 8'd253, 32'hcafe0001};
        vecs[14] = '{1'b1, 10'h3f4, 32'h0,        32'hcafe0001, 1'b1, 1'b0, 8'd0,  32'h0};
        vecs[15] = '{1'b1, 10'h0c0, 32'h0,        32'h00000000, 1'b0, 1'b0, 8'd0,  32'h0};

        rst_n = 1'b0; req = 1'b0; isRead = 1'b1; address = '0; writeData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset readData", readData, 32'd0);
        chk("reset isHit", {31'd0, isHit}, 32'd0);
        chk("init mem[128]", dut.mem.mem[128], 32'h00000ccc);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            access(vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].exp_d, vecs[i].exp_h, i);
            if (vecs[i].probe)
                chk($sformatf("vec%0d mem[%0d]", i, vecs[i].pidx), dut.mem.mem[vecs[i].pidx], vecs[i].pval);
        end

        // Idle: a hit, then 3 cycles of req=0 with a would-be store on the bus.
        access(1'b1, 10'h3f4, 32'h0, 32'hcafe0001, 1'b1, 100);
        held_d = 32'hcafe0001; held_h = 1'b1;
        @(negedge clk);
        isRead = 1'b0; address = 10'h3f4; writeData = 32'h5555aaaa;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle%0d readData", c), readData, held_d);
            chk($sformatf("idle%0d isHit", c), {31'd0, isHit}, {31'd0, held_h});
        end
        chk("idle mem[253]", dut.mem.mem[253], 32'hcafe0001);

        // Async reset mid-cycle after filling line 0.
        access(1'b1, 10'h000, 32'h0, 32'h000000ff, 1'b0, 200);
        access(1'b1, 10'h000, 32'h0, 32'h000000ff, 1'b1, 201);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst readData", readData, 32'd0);
        chk("async rst isHit", {31'd0, isHit}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        access(1'b1, 10'h000, 32'h0, 32'h000000ff, 1'b0, 202);
        access(1'b1, 10'h3f4, 32'h0, 32'hcafe0001, 1'b0, 203);
        chk("post rst mem[17]", dut.mem.mem[17], 32'h12345678);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish within the time budget");
        $fatal(1);
    end
endmodule
